// File: rtl/conv_1x1_read_ctrl_if.sv
// Signal bundle between the pipeline-buffer writer/1x1 cluster and the read sequencer.
interface conv_1x1_read_ctrl_if;
  logic        start;
  logic        pixel_written;
  logic        buf_full;
  logic [31:0] addr_ram_next_rd;
  logic [31:0] addr_w_n_state;
  logic [3:0]  PE_reset_n_state;
  logic        ofm_valid;
  logic [3:0]  ofm_group;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output start, pixel_written,
    input  buf_full, addr_ram_next_rd, addr_w_n_state, PE_reset_n_state,
    input  ofm_valid, ofm_group, busy, done, overflow
  );

  modport slave (
    input  start, pixel_written,
    output buf_full, addr_ram_next_rd, addr_w_n_state, PE_reset_n_state,
    output ofm_valid, ofm_group, busy, done, overflow
  );
endinterface

// File: rtl/conv_1x1_read_ctrl.sv
// Read sequencer for the 3x3->1x1 pipeline buffer: pixel credits, BRAM/weight addressing,
// PE accumulator clear and per-group result strobes.
module conv_1x1_read_ctrl #(
  parameter int WORDS_PER_PIXEL = 4,
  parameter int OUT_GROUPS      = 16,
  parameter int DEPTH_PIXELS    = 8,
  parameter int TOTAL_PIXELS    = 3136
) (
  input logic                  clk,
  input logic                  reset_n,
  conv_1x1_read_ctrl_if.slave  bus
);
  localparam int WW   = (WORDS_PER_PIXEL > 1) ? $clog2(WORDS_PER_PIXEL) : 1;
  localparam int GW   = (OUT_GROUPS > 1) ? $clog2(OUT_GROUPS) : 1;
  localparam int CW   = $clog2(DEPTH_PIXELS + 1);
  localparam int RING = DEPTH_PIXELS * WORDS_PER_PIXEL;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_FLUSH, S_DONE} state_t;

  state_t          state_r, state_next_s;
  logic [CW-1:0]   credits_r, credits_next_s;
  logic [WW-1:0]   w_r;
  logic [GW-1:0]   g_r, grp_r, grp_d_r;
  logic [31:0]     pix_r, base_r, addr_rd_r, addr_w_r;
  logic [1:0]      fcnt_r;
  logic            first_r, grp_last_r, pix_last_r, final_r, overflow_r;
  logic            last_d_r, ofm_valid_r, busy_r, done_r;
  logic [3:0]      pe_reset_r, ofm_group_r;
  logic            full_s, accept_s, release_s, issue_s, w_last_s, g_last_s;

  assign full_s    = (credits_r == CW'(DEPTH_PIXELS));
  assign accept_s  = bus.pixel_written && !full_s;
  // The credit of a pixel is returned the cycle after its final address is on the bus.
  assign release_s = (state_r == S_READ) && pix_last_r;
  assign w_last_s  = (w_r == WW'(WORDS_PER_PIXEL - 1));
  assign g_last_s  = (g_r == GW'(OUT_GROUPS - 1));

  // Credit arithmetic including this cycle's write and release.
  always_comb begin
    credits_next_s = credits_r;
    if (accept_s && !release_s) begin
      credits_next_s = credits_r + CW'(1);
    end else if (!accept_s && release_s) begin
      credits_next_s = credits_r - CW'(1);
    end else begin
      credits_next_s = credits_r;
    end
  end

  // Next-state and address-issue decision.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_next_s = S_WAIT;
        else           state_next_s = S_IDLE;
      end
      S_WAIT: begin
        if (credits_next_s != CW'(0)) begin
          state_next_s = S_READ;
          issue_s      = 1'b1;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_READ: begin
        if (final_r) begin
          state_next_s = S_FLUSH;
        end else if (!pix_last_r || (credits_next_s != CW'(0))) begin
          state_next_s = S_READ;
          issue_s      = 1'b1;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (fcnt_r == 2'd2) state_next_s = S_DONE;
        else                state_next_s = S_FLUSH;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, credits, loop counters and the issued-address register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      credits_r  <= '0;
      w_r        <= '0;
      g_r        <= '0;
      pix_r      <= 32'd0;
      base_r     <= 32'd0;
      addr_rd_r  <= 32'd0;
      addr_w_r   <= 32'd0;
      first_r    <= 1'b0;
      grp_last_r <= 1'b0;
      pix_last_r <= 1'b0;
      final_r    <= 1'b0;
      grp_r      <= '0;
      fcnt_r     <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      fcnt_r  <= (state_r == S_FLUSH) ? fcnt_r + 2'd1 : 2'd0;
      if ((state_r == S_IDLE) && bus.start) begin
        credits_r  <= '0;
        w_r        <= '0;
        g_r        <= '0;
        pix_r      <= 32'd0;
        base_r     <= 32'd0;
        overflow_r <= 1'b0;
      end else begin
        credits_r <= credits_next_s;
        if (bus.pixel_written && full_s) overflow_r <= 1'b1;
        if (issue_s) begin
          addr_rd_r  <= base_r + 32'(w_r);
          addr_w_r   <= 32'(g_r) * 32'(WORDS_PER_PIXEL) + 32'(w_r);
          first_r    <= (w_r == WW'(0));
          grp_last_r <= w_last_s;
          pix_last_r <= w_last_s && g_last_s;
          final_r    <= w_last_s && g_last_s && (pix_r == 32'(TOTAL_PIXELS - 1));
          grp_r      <= g_r;
          if (w_last_s) begin
            w_r <= '0;
            if (g_last_s) begin
              g_r    <= '0;
              pix_r  <= pix_r + 32'd1;
              base_r <= (base_r + 32'(WORDS_PER_PIXEL) >= 32'(RING)) ? 32'd0
                                                                     : base_r + 32'(WORDS_PER_PIXEL);
            end else begin
              g_r <= g_r + GW'(1);
            end
          end else begin
            w_r <= w_r + WW'(1);
          end
        end
      end
    end
  end

  // Output pipeline aligned to the one-cycle BRAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_reset_r  <= 4'h0;
      last_d_r    <= 1'b0;
      grp_d_r     <= '0;
      ofm_valid_r <= 1'b0;
      ofm_group_r <= 4'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pe_reset_r  <= ((state_r == S_READ) && first_r) ? 4'hF : 4'h0;
      last_d_r    <= (state_r == S_READ) && grp_last_r;
      grp_d_r     <= grp_r;
      ofm_valid_r <= last_d_r;
      ofm_group_r <= 4'(grp_d_r);
      busy_r      <= (state_next_s == S_WAIT) || (state_next_s == S_READ) ||
                     (state_next_s == S_FLUSH);
      done_r      <= (state_next_s == S_DONE);
    end
  end

  assign bus.buf_full         = full_s;
  assign bus.addr_ram_next_rd = addr_rd_r;
  assign bus.addr_w_n_state   = addr_w_r;
  assign bus.PE_reset_n_state = pe_reset_r;
  assign bus.ofm_valid        = ofm_valid_r;
  assign bus.ofm_group        = ofm_group_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.overflow         = overflow_r;
endmodule

// File: doc/conv_1x1_read_ctrl.md
# conv_1x1_read_ctrl

Read-side sequencer for the inter-stage pipeline buffer between the 3x3 PE cluster and the 1x1 PE cluster. The 3x3 stage writes each finished output pixel into the pipeline BRAM as `WORDS_PER_PIXEL` 32-bit words and pulses `pixel_written`. This block tracks buffer occupancy in pixel credits and generates the pipeline-BRAM read address, the 1x1 weight-BRAM address and the 1x1 PE accumulator reset. It reports result validity for each group of 4 output channels and back-pressures the writer when the buffer is full.

## Interface
Parameters:
- `WORDS_PER_PIXEL`, 4: 32-bit words per pixel (16 channels x 8 bit).
- `OUT_GROUPS`, 16: 1x1 output channels / 4 (filters per PE_cluster_1x1 pass).
- `DEPTH_PIXELS`, 8: pipeline buffer capacity in pixels; buffer is `DEPTH_PIXELS*WORDS_PER_PIXEL` words, ring-addressed from 0.
- `TOTAL_PIXELS`, 3136: pixels per layer (56x56).

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a layer (accepted in IDLE only).
- `pixel_written` in 1: one-cycle pulse; writer finished one full pixel.
- `buf_full` out 1: credits == `DEPTH_PIXELS`; writer must not pulse `pixel_written`.
- `addr_ram_next_rd` out 32: pipeline BRAM read address (registered).
- `addr_w_n_state` out 32: 1x1 weight BRAM read address (registered).
- `PE_reset_n_state` out 4: accumulator clear for the 4 PEs of PE_cluster_1x1.
- `ofm_valid` out 1: OFM_0..3_n_state hold a finished group result this cycle.
- `ofm_group` out 4: group index of the result flagged by `ofm_valid`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at layer end.
- `overflow` out 1: sticky; `pixel_written` seen while `buf_full`; cleared by `start`.

## Operation
- State machine: IDLE -> (`start`) WAIT -> (credits>0) READ -> (pixel consumed, credits left, more pixels) READ / (credits==0) WAIT / (last pixel consumed) FLUSH -> 2 cycles -> DONE -> IDLE.
- `start` in IDLE clears credits, read base, word/group/pixel counters and `overflow`. `start` outside IDLE is ignored.
- READ issues one address per cycle, no bubbles. Inner loop: word w = 0..`WORDS_PER_PIXEL`-1. Outer loop: group g = 0..`OUT_GROUPS`-1. The same pixel is re-read for every group.
- `addr_ram_next_rd` = base + w. Base advances by `WORDS_PER_PIXEL` per consumed pixel and wraps to 0 at `DEPTH_PIXELS*WORDS_PER_PIXEL`.
- `addr_w_n_state` = g*`WORDS_PER_PIXEL` + w. Weights repeat per pixel.
- Credits: +1 on `pixel_written` (saturating at `DEPTH_PIXELS`; if full, pulse ignored and `overflow` set). -1 when the address (w=last, g=last) is issued. Simultaneous +1/-1 leaves credits unchanged.
- Pixels written beyond `TOTAL_PIXELS` are counted but not consumed; the layer ends after `TOTAL_PIXELS` consumptions.
- Reset mid-layer: all state returns to reset values immediately; in-flight results are discarded (`ofm_valid` low).

## Timing
- Reset values: `addr_ram_next_rd`=0, `addr_w_n_state`=0, `PE_reset_n_state`=4'h0, `ofm_valid`=0, `ofm_group`=0, `buf_full`=0, `busy`=0, `done`=0, `overflow`=0.
- BRAM latency is 1 cycle. Address presented in cycle t gives data at the PE in t+1.
- `PE_reset_n_state`=4'hF in the cycle the w=0 word of each group reaches the PE (t+1 for w=0 issued at t). The PE loads rather than accumulates that word. Otherwise 4'h0.
- `ofm_valid`=1 with `ofm_group`=g in cycle t+2, where t is the cycle the w=last address of group g is issued. Throughput: one result per `WORDS_PER_PIXEL` cycles in steady state.
- Credit release is visible at t+1 for the last address issued at t. `buf_full` is combinational from the credit register.
- From WAIT, the first address is issued the cycle after credits become >0. A `pixel_written` pulse at t gives an address at t+1 and `PE_reset_n_state` at t+2.
- `done` pulses 2 cycles after the final `ofm_valid`. `busy` falls in the same cycle as `done`.

## Test plan
- Single pixel, `TOTAL_PIXELS`=1: `start`, then `pixel_written` at cycle 5 -> 64 reads (rd addr 0,1,2,3 repeated; w addr 0..63), 16 `ofm_valid` pulses with `ofm_group` 0..15 every 4 cycles, then `done`.
- Backpressure: 8 `pixel_written` pulses before any read starts (reader held by delaying `start` path) -> `buf_full`=1. A 9th pulse sets `overflow`=1 and credits stay 8.
- Wrap-around: stream 10 pixels with writer always ahead -> rd base sequence 0,4,...,28,0,4. Consumption is continuous with no WAIT cycles.
- Starvation: writer pulses every 100 cycles -> WAIT between pixels, with no `PE_reset_n_state` or `ofm_valid` during WAIT. First address appears 1 cycle after each pulse.
- Simultaneous events: `pixel_written` in the same cycle as the last address of a pixel with credits=1 -> credits stay 1 and READ continues without a bubble.
- Async reset asserted mid-group -> all outputs at reset values immediately. A later `start` restarts at rd addr 0, w addr 0.
